// File: rtl/mul_div_pkg.sv
// Shared constants and types for the sequential RV32M multiply/divide unit.
// Holds the operand width, the iteration count, the func3 op encoding and the FSM states.
package mul_div_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ITER = 32;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    function automatic logic op_a_signed(input op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// shift-subtract for divide, on a 2*XLEN+1 bit accumulator.
module mul_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN:0]   acc_next
);

    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] shl;
    logic [XLEN+1:0] trial;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half the partial product.
        mul_sum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, op_b} : {(XLEN+1){1'b0}});
        shl     = {acc[2*XLEN-1:0], 1'b0};
        trial   = {1'b0, shl[2*XLEN:XLEN]} - {2'b00, op_b};
        if (is_div) begin
            if (!trial[XLEN+1]) begin
                acc_next = {trial[XLEN:0], shl[XLEN-1:1], 1'b1};
            end else begin
                acc_next = shl;
            end
        end else begin
            acc_next = {1'b0, mul_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential RV32M multiply/divide unit: fixed ITER-cycle latency for every op,
// magnitude arithmetic with sign correction applied as the result is registered.
module mul_div_seq #(
    parameter int unsigned XLEN = mul_div_pkg::XLEN,
    parameter int unsigned ITER = mul_div_pkg::ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    import mul_div_pkg::*;

    localparam int unsigned CW = $clog2(ITER + 1);

    state_e          state_q;
    op_e             func_q;
    logic            a_neg_q, b_neg_q;
    logic [XLEN-1:0] b_mag_q;
    logic [2*XLEN:0] acc_q, acc_next;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;
    logic            busy_q, done_q;

    op_e             op_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, result_d;

    mul_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div   (func_q[2]),
        .acc      (acc_q),
        .op_b     (b_mag_q),
        .acc_next (acc_next)
    );

    always_comb begin
        op_in    = op_e'(func3);
        a_neg_in = op_a_signed(op_in) & rs1[XLEN-1];
        b_neg_in = op_b_signed(op_in) & rs2[XLEN-1];
        a_mag_in = a_neg_in ? -rs1 : rs1;
        b_mag_in = b_neg_in ? -rs2 : rs2;
    end

    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -acc_next[2*XLEN-1:0] : acc_next[2*XLEN-1:0];
        // Divide by zero must leave the all-ones quotient unnegated.
        quot_fix = ((a_neg_q ^ b_neg_q) && (b_mag_q != '0)) ? -acc_next[XLEN-1:0]
                                                            : acc_next[XLEN-1:0];
        rem_fix  = a_neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        unique case (func_q)
            OpMul:                     result_d = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: result_d = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             result_d = quot_fix;
            OpRem, OpRemu:             result_d = rem_fix;
            default:                   result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            func_q   <= OpMul;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        func_q  <= op_in;
                        a_neg_q <= a_neg_in;
                        b_neg_q <= b_neg_in;
                        b_mag_q <= b_mag_in;
                        acc_q   <= {{(XLEN+1){1'b0}}, a_mag_in};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        result_q <= result_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign stall  = ((state_q == StIdle) && start) || (state_q == StCalc);

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed corner cases plus random ops
// compared against a plain-arithmetic RV32M reference model.
module tb_mul_div_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, result;
    logic        busy, done, stall;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    mul_div_seq #(
        .XLEN(32),
        .ITER(32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .result (result),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pv;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            default: p = 0;
        endcase
        pv = p;
        case (f)
            3'd0: r = pv[31:0];
            3'd1, 3'd2, 3'd3: r = pv[63:32];
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin pv = sa / sb; r = pv[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin pv = sa % sb; r = pv[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issues one op starting at the next falling edge (cycle 0) and checks it through cycle 33.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit restart);
        logic [31:0] exp;
        exp = ref_model(f, a, b);
        @(negedge clk);
        start = 1'b1; func3 = f; rs1 = a; rs2 = b;
        #1;
        check("stall_on_start", 32'(stall), 32'd1);
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            check("calc_busy", 32'(busy), 32'd1);
            check("calc_done_low", 32'(done), 32'd0);
            if (cyc == 16) begin
                check("result_hold", result, last_result);
                check("calc_stall", 32'(stall), 32'd1);
            end
            rs1   = $urandom;
            rs2   = $urandom;
            func3 = 3'($urandom);
            start = restart && (cyc == 10);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_stall_low", 32'(stall), 32'd0);
        check($sformatf("result f=%0d a=%h b=%h", f, a, b), result, exp);
        last_result = exp;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; func3 = 3'd0; rs1 = '0; rs2 = '0;
        last_result = '0;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 1'b0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 1'b0);
        run_op(3'd7, 32'd5, 32'd0, 1'b0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(3'd4, 32'hFFFFFFFB, 32'd0, 1'b0);
        run_op(3'd6, 32'hFFFFFFFB, 32'd0, 1'b0);
        run_op(3'd0, 32'd12345, 32'd678, 1'b1);

        // Reset in cycle 15 of CALC aborts the op without a done pulse.
        @(negedge clk);
        start = 1'b1; func3 = 3'd1; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        start = 1'b1;
        #1;
        check("midrst_stall_start", 32'(stall), 32'd1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("aborted_no_done", 32'(done), 32'd0);
        end
        last_result = '0;
        run_op(3'd3, 32'd3, 32'd4, 1'b0);

        for (int k = 0; k < 24; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            case (k % 4)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 16));
                2: b = -32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            run_op(f, a, b, (k % 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
